// File: rtl/keypad_scanner.sv
// Purpose : scan a 4x4 active-low matrix keypad one column at a time, debounce whole-scan results, emit hex key events.
// Latency : event DEBOUNCE_SCANS full scans (4*SCAN_DIV cycles each) + 1 cycle after a stable press; release likewise.
// Backpr. : none; KeyValid is a one-cycle pulse with no ready, downstream must capture it on that cycle.
// Ports   : Clock, Reset (sync, active-high); Row[3:0] in (active-low, async); Col[3:0] out (one-hot-low);
//           KeyCode[3:0] last accepted key; KeyValid one-cycle event; KeyHeld high from acceptance to debounced release.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] Row,
  output logic [3:0] Col,
  output logic [3:0] KeyCode,
  output logic       KeyValid,
  output logic       KeyHeld
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } res_kind_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESSED = 1'b1
  } state_t;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Synchronizer
  logic [3:0]    row_meta_q, row_meta_d;
  logic [3:0]    row_sync_q, row_sync_d;
  // Scan timing
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_q, col_d;
  // Per-scan accumulation (count saturates at 2: anything above one key is MULTI)
  logic [1:0]    acc_cnt_q, acc_cnt_d;
  logic [1:0]    acc_row_q, acc_row_d;
  logic [1:0]    acc_col_q, acc_col_d;
  // Debounce
  res_kind_t     prev_kind_q, prev_kind_d;
  logic [3:0]    prev_code_q, prev_code_d;
  logic [SW-1:0] stable_q, stable_d;
  // Key FSM and outputs
  state_t        state_q, state_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;

  logic          sample;
  logic          scan_done;
  logic [3:0]    pressed;
  logic [2:0]    hits;
  logic [1:0]    hit_row;
  logic [2:0]    total;
  logic [1:0]    pos_row;
  logic [1:0]    pos_col;
  res_kind_t     res_kind;
  logic [3:0]    res_code;
  logic          stable_reached;

  // Synchronizer and column dwell counter
  always_comb begin
    row_meta_d = Row;
    row_sync_d = row_meta_q;
    sample     = (dwell_q == DWELL_LAST);
    dwell_d    = dwell_q + 1'b1;
    col_d      = col_q;
    if (sample) begin
      dwell_d = '0;
      col_d   = col_q + 2'd1;
    end
  end

  // Column sample accumulation and end-of-scan classification
  always_comb begin
    acc_cnt_d = acc_cnt_q;
    acc_row_d = acc_row_q;
    acc_col_d = acc_col_q;
    scan_done = sample && (col_q == 2'd3);
    pressed   = ~row_sync_q;
    hits      = '0;
    hit_row   = '0;
    res_kind  = RES_NONE;
    res_code  = '0;

    for (int i = 0; i < 4; i++) begin
      hits = hits + {2'b00, pressed[i]};
    end
    // Lowest pressed row in this column; only meaningful when one key in total is down.
    for (int i = 3; i >= 0; i--) begin
      if (pressed[i]) begin
        hit_row = 2'(i);
      end
    end

    total   = {1'b0, acc_cnt_q} + hits;
    pos_row = (acc_cnt_q == 2'd0) ? hit_row : acc_row_q;
    pos_col = (acc_cnt_q == 2'd0) ? col_q   : acc_col_q;

    if (sample) begin
      if (scan_done) begin
        acc_cnt_d = '0;
        acc_row_d = '0;
        acc_col_d = '0;
        if (total == 3'd0) begin
          res_kind = RES_NONE;
        end else if (total == 3'd1) begin
          res_kind = RES_SINGLE;
          res_code = key_map(pos_row, pos_col);
        end else begin
          res_kind = RES_MULTI;
        end
      end else begin
        acc_cnt_d = (total >= 3'd2) ? 2'd2 : total[1:0];
        acc_row_d = pos_row;
        acc_col_d = pos_col;
      end
    end
  end

  // Debounce counter and key FSM
  always_comb begin
    prev_kind_d    = prev_kind_q;
    prev_code_d    = prev_code_q;
    stable_d       = stable_q;
    state_d        = state_q;
    key_code_d     = key_code_q;
    key_valid_d    = 1'b0;
    key_held_d     = key_held_q;
    stable_reached = 1'b0;

    if (scan_done) begin
      prev_kind_d = res_kind;
      prev_code_d = res_code;
      // Non-SINGLE results carry code 0, so a plain compare covers all kinds.
      if (res_kind == prev_kind_q && res_code == prev_code_q) begin
        stable_d = (stable_q == STABLE_MAX) ? STABLE_MAX : stable_q + 1'b1;
      end else begin
        stable_d = SW'(1);
      end
      stable_reached = (stable_d == STABLE_MAX);

      case (state_q)
        ST_IDLE: begin
          if (res_kind == RES_SINGLE && stable_reached) begin
            state_d     = ST_PRESSED;
            key_code_d  = res_code;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
          end
        end
        ST_PRESSED: begin
          // Other keys and chords are ignored until everything is released.
          if (res_kind == RES_NONE && stable_reached) begin
            state_d    = ST_IDLE;
            key_held_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      row_meta_q  <= 4'hF;
      row_sync_q  <= 4'hF;
      dwell_q     <= '0;
      col_q       <= '0;
      acc_cnt_q   <= '0;
      acc_row_q   <= '0;
      acc_col_q   <= '0;
      prev_kind_q <= RES_NONE;
      prev_code_q <= '0;
      stable_q    <= '0;
      state_q     <= ST_IDLE;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      row_meta_q  <= row_meta_d;
      row_sync_q  <= row_sync_d;
      dwell_q     <= dwell_d;
      col_q       <= col_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_row_q   <= acc_row_d;
      acc_col_q   <= acc_col_d;
      prev_kind_q <= prev_kind_d;
      prev_code_q <= prev_code_d;
      stable_q    <= stable_d;
      state_q     <= state_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign Col      = ~(4'b0001 << col_q);
  assign KeyCode  = key_code_q;
  assign KeyValid = key_valid_q;
  assign KeyHeld  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Purpose : randomized and directed check of keypad_scanner against a per-scan reference model.
// Latency : n/a (testbench).
// Backpr. : n/a (testbench).
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 2;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [3:0]  Row;
  logic [3:0]  Col;
  logic [3:0]  KeyCode;
  logic        KeyValid;
  logic        KeyHeld;
  logic [15:0] keys = '0;   // bit r*4+c = key at row r, column c held down

  int checks   = 0;
  int failures = 0;
  int n_pulse  = 0;

  // Reference model state, updated once per full scan
  int          m_prev;      // -1 none, -2 multi, else key code
  int          m_stable;
  bit          m_held;
  logic [3:0]  m_code;
  bit          m_valid_pend;

  logic [3:0]  kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                             4'h4, 4'h5, 4'h6, 4'hB,
                             4'h7, 4'h8, 4'h9, 4'hC,
                             4'hE, 4'h0, 4'hF, 4'hD};

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Row     (Row),
    .Col     (Col),
    .KeyCode (KeyCode),
    .KeyValid(KeyValid),
    .KeyHeld (KeyHeld)
  );

  always #5 Clock = ~Clock;

  // Keypad matrix: a held key pulls its row low while its column is driven low.
  always_comb begin
    Row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !Col[c]) Row[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev       = -1;
    m_stable     = 0;
    m_held       = 0;
    m_code       = 4'h0;
    m_valid_pend = 0;
  endtask

  // One full scan with key set k, judged by the key-count rule and the debounce rules.
  task automatic model_scan(input logic [15:0] k);
    int n;
    int res;
    n   = $countones(k);
    res = -1;
    if (n == 1) begin
      for (int i = 0; i < 16; i++)
        if (k[i]) res = int'(kmap[i]);
    end else if (n > 1) begin
      res = -2;
    end
    if (res == m_prev) m_stable = (m_stable + 1 > DB) ? DB : m_stable + 1;
    else               m_stable = 1;
    m_prev       = res;
    m_valid_pend = 0;
    if (!m_held && res >= 0 && m_stable == DB) begin
      m_held       = 1;
      m_code       = 4'(res);
      m_valid_pend = 1;
    end else if (m_held && res == -1 && m_stable == DB) begin
      m_held = 0;
    end
  endtask

  // Entered at the falling edge of the first cycle of a scan; leaves at the same point of the next.
  task automatic run_scan(input logic [15:0] k);
    logic [3:0] exp_col;
    for (int cyc = 0; cyc < 4*SD; cyc++) begin
      if (cyc == 0) begin
        chk("valid_evt", KeyValid, m_valid_pend);
        keys = k;
      end else begin
        chk("valid_quiet", KeyValid, 1'b0);
      end
      if (KeyValid) n_pulse++;
      exp_col = 4'b0001 << (cyc / SD);
      exp_col = ~exp_col;
      chk("col", Col, exp_col);
      chk("held", KeyHeld, m_held);
      chk("code", KeyCode, m_code);
      @(negedge Clock);
    end
    model_scan(k);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    chk("rst_col", Col, 4'hE);
    chk("rst_code", KeyCode, 4'h0);
    chk("rst_valid", KeyValid, 1'b0);
    chk("rst_held", KeyHeld, 1'b0);
    Reset = 1'b0;
    model_reset();
  endtask

  localparam logic [15:0] K_5    = 16'h0001 << 5;   // row1 col1
  localparam logic [15:0] K_1    = 16'h0001 << 0;   // row0 col0
  localparam logic [15:0] K_2    = 16'h0001 << 1;   // row0 col1
  localparam logic [15:0] K_A    = 16'h0001 << 3;   // row0 col3
  localparam logic [15:0] K_HASH = 16'h0001 << 14;  // row3 col2
  localparam logic [15:0] K_7    = 16'h0001 << 8;   // row2 col0

  int          n0;
  int          sel;
  logic [15:0] rk;

  initial begin
    model_reset();
    do_reset();

    // Idle scanning: column walk and no events
    n0 = n_pulse;
    repeat (2) run_scan('0);
    chk("idle_pulses", n_pulse - n0, 0);

    // Single key '5' held, then released
    n0 = n_pulse;
    repeat (4) run_scan(K_5);
    chk("k5_code", KeyCode, 4'h5);
    chk("k5_held", KeyHeld, 1'b1);
    repeat (3) run_scan('0);
    chk("k5_rel_held", KeyHeld, 1'b0);
    chk("k5_rel_code", KeyCode, 4'h5);
    chk("k5_pulses", n_pulse - n0, 1);

    // Bouncing key never settles
    n0 = n_pulse;
    for (int i = 0; i < 8; i++) run_scan((i % 2 == 0) ? K_5 : 16'h0000);
    run_scan('0);
    chk("bounce_pulses", n_pulse - n0, 0);
    chk("bounce_held", KeyHeld, 1'b0);

    // Chord, then one key lifted
    n0 = n_pulse;
    repeat (3) run_scan(K_1 | K_2);
    chk("chord_pulses", n_pulse - n0, 0);
    repeat (3) run_scan(K_1);
    chk("chord_code", KeyCode, 4'h1);
    repeat (3) run_scan('0);
    chk("chord_total", n_pulse - n0, 1);

    // '#' held, 'A' added, '#' lifted: no second event until full release
    n0 = n_pulse;
    repeat (3) run_scan(K_HASH);
    chk("hash_code", KeyCode, 4'hF);
    chk("hash_held", KeyHeld, 1'b1);
    repeat (2) run_scan(K_HASH | K_A);
    repeat (3) run_scan(K_A);
    chk("hash_code_kept", KeyCode, 4'hF);
    chk("hash_one_pulse", n_pulse - n0, 1);
    repeat (3) run_scan('0);
    chk("hash_rel_held", KeyHeld, 1'b0);
    repeat (3) run_scan(K_A);
    chk("a_code", KeyCode, 4'hA);
    repeat (3) run_scan('0);
    chk("hash_a_pulses", n_pulse - n0, 2);

    // Reset with '7' half debounced; event comes 2 scans after restart
    n0 = n_pulse;
    run_scan(K_7);
    do_reset();
    repeat (3) run_scan(K_7);
    chk("rst7_code", KeyCode, 4'h7);
    chk("rst7_pulses", n_pulse - n0, 1);
    repeat (3) run_scan('0);

    // Random key sequences: none, single, or pairs, each held 1..4 scans
    for (int b = 0; b < 40; b++) begin
      sel = $urandom_range(0, 3);
      rk  = '0;
      if (sel >= 1) rk[$urandom_range(0, 15)] = 1'b1;
      if (sel == 3) rk[$urandom_range(0, 15)] = 1'b1;
      repeat ($urandom_range(1, 4)) run_scan(rk);
    end
    repeat (3) run_scan('0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
